// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache memory port arbiter: widths,
// FSM state encoding, grant-side encoding and tie-break helper.
package mem_arbiter_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    // Round-robin pick: on a tie the side not served last wins.
    function automatic side_t pick_side(
        input logic  i_req,
        input logic  d_req,
        input side_t last
    );
        if (i_req && d_req) begin
            return (last == SIDE_I) ? SIDE_D : SIDE_I;
        end
        return d_req ? SIDE_D : SIDE_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the arbiter.
// master: arbiter view; slave: cache/memory environment view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_perf_counter.sv
// Saturating enable counter for performance statistics.
// Ports: clk, rst (async active-low), clr (sync clear), en, count.
module perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I and D caches.
// Ports: clk, rst (async active-low), bus (master), busy_cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.master    bus,
    output logic [CNT_W-1:0] busy_cycles
);

    arb_state_t state;
    arb_state_t state_nxt;
    side_t      last_gnt;
    side_t      last_gnt_nxt;

    logic i_req;
    logic d_req;
    logic busy_en;

    assign i_req   = bus.i_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign busy_en = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= SIDE_I;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Strobes come from registered state only; ready and read data
    // are forwarded in the same cycle as mem_ready.
    always_comb begin
        state_nxt     = state;
        last_gnt_nxt  = last_gnt;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_ready   = 1'b0;
        bus.i_rdata   = '0;
        bus.d_ready   = 1'b0;
        bus.d_rdata   = '0;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (pick_side(i_req, d_req, last_gnt) == SIDE_D) begin
                        state_nxt = GNT_D;
                    end else begin
                        state_nxt = GNT_I;
                    end
                end
            end
            GNT_I: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = bus.i_addr;
                if (bus.mem_ready) begin
                    bus.i_ready  = 1'b1;
                    bus.i_rdata  = bus.mem_rdata;
                    last_gnt_nxt = SIDE_I;
                    state_nxt    = TURN;
                end
            end
            GNT_D: begin
                // A write-back wins over a simultaneous read.
                bus.mem_write = bus.d_write;
                bus.mem_read  = bus.d_read & ~bus.d_write;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                if (bus.mem_ready) begin
                    bus.d_ready  = 1'b1;
                    bus.d_rdata  = bus.mem_rdata;
                    last_gnt_nxt = SIDE_D;
                    state_nxt    = TURN;
                end
            end
            TURN: begin
                // Dead cycle lets the served cache drop its request.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    perf_counter #(
        .W (CNT_W)
    ) u_busy_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (busy_en),
        .count (busy_cycles)
    );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single off-chip memory port between the instruction-cache and data-cache miss handlers in the pipelined CPU. It serialises block reads and write-backs, applies round-robin priority on conflicts, routes the memory's one-cycle ready pulse and read data back to the granted cache, and keeps a saturating busy-cycle counter for bench performance reporting.

## Interface
- ADDR_W, 28, block address width (word address >> 2)
- DATA_W, 128, block data width (4 words)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_read  input  1  I-cache block read request, held until i_ready
- i_addr  input  ADDR_W  I-cache block address, stable while i_read
- i_rdata  output  DATA_W  read data to I-cache, valid when i_ready
- i_ready  output  1  one-cycle completion pulse to I-cache
- d_read  input  1  D-cache block read request, held until d_ready
- d_write  input  1  D-cache write-back request, held until d_ready
- d_addr  input  ADDR_W  D-cache block address, stable while request held
- d_wdata  input  DATA_W  write-back data, stable while d_write
- d_rdata  output  DATA_W  read data to D-cache, valid when d_ready
- d_ready  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory block address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion pulse, exactly one cycle
- busy_cycles  output  16  count of cycles with mem_read|mem_write high, saturates at 16'hFFFF

## Operation
- States: IDLE, GNT_I, GNT_D, TURN.
- IDLE: if only I requests -> GNT_I; only D requests -> GNT_D; both -> side not served last (last_gnt register); no request -> stay.
- last_gnt resets to I, so the first tie after reset goes to D.
- D request with d_read and d_write both high is treated as write; read ignored.
- GNT_I: mem_read=1, mem_addr=i_addr; mem_write=0. On mem_ready: i_ready=1, i_rdata=mem_rdata, last_gnt<=I, -> TURN.
- GNT_D: mem_write=d_write, mem_read=d_read&~d_write, mem_addr=d_addr, mem_wdata=d_wdata. On mem_ready: d_ready=1, d_rdata=mem_rdata, last_gnt<=D, -> TURN.
- TURN: all memory strobes low for one cycle (requester drops its request after ready); -> IDLE unconditionally.
- i_rdata/d_rdata forward mem_rdata combinationally; qualified only by the ready pulse. Ready to non-granted side is always 0.
- mem_ready outside GNT_I/GNT_D is ignored.
- Request withdrawn mid-grant is a protocol violation; arbiter stays in grant state until mem_ready.
- busy_cycles increments each cycle mem_read|mem_write is high; holds at FFFF.

## Timing
- Reset: state IDLE, last_gnt=I, busy_cycles=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0.
- Strobes are decoded from registered state only: request sampled in IDLE at edge t -> mem strobe high from cycle t+1.
- Ready pulse to cache is same cycle as mem_ready (combinational).
- Minimum back-to-back spacing: ready cycle, TURN cycle, IDLE cycle, next grant; 3 cycles between completion and next strobe.
- Reset asserted mid-grant: strobes drop immediately (async), no ready issued, pending request re-arbitrated after release.

## Structure
- Shared package: state encoding constants (IDLE, GNT_I, GNT_D, TURN), ADDR_W/DATA_W defaults, last_gnt encoding.
- Optional sub-module perf_counter (saturating 16-bit enable counter) for busy_cycles; reused by cache hit/miss statistics.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, busy_cycles=0.
- i_read, i_addr=28'h10; memory responds 4 cycles later with rdata=128'hA5.. -> mem_read high 4 cycles, i_ready one pulse with i_rdata=A5.., busy_cycles=4.
- i_read and d_write asserted same cycle after reset -> D granted first (mem_write, d_wdata on bus), then I after TURN+IDLE.
- Both request continuously for 4 transactions -> grants alternate D,I,D,I; no ready on wrong side.
- d_read and d_write both high -> mem_write=1, mem_read=0.
- Reset pulsed during GNT_D -> strobes drop at once, no d_ready; after release held d_read re-granted, completes normally.
